// File: rtl/ysyx_23060042_fetch.sv
// Instruction fetch stage: owns the PC and keeps one instruction-memory read in flight.
// It hands each word, with its PC and fault flag, to decode; a redirect squashes any in-flight fetch.
module ysyx_23060042_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic [31:0] target;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign target     = align_pc(redirect_pc);
  assign req_valid  = (state == REQ);
  assign req_addr   = pc;
  assign inst_valid = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
      inst_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (redirect_valid) pc <= target;
        end
        REQ: begin
          // The address may still change before acceptance; a redirect in the
          // accepting cycle means the response belongs to the old path.
          if (redirect_valid) pc <= target;
          if (req_ready) begin
            state <= WAIT;
            drop  <= redirect_valid;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            drop <= 1'b0;
            if (!drop && !redirect_valid) begin
              inst       <= rsp_data;
              inst_pc    <= pc;
              inst_fault <= rsp_err;
              pc         <= pc + 32'd4;
              state      <= HOLD;
            end else begin
              if (redirect_valid) pc <= target;
              state <= REQ;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
            pc   <= target;
          end
        end
        HOLD: begin
          // Redirect wins over a same-cycle decode acceptance.
          if (redirect_valid) begin
            pc    <= target;
            state <= REQ;
          end else if (inst_ready) begin
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060042_fetch.sv
// Bench for the fetch stage: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of expected fetch addresses and delivered instructions.
module tb_ysyx_23060042_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ysyx_23060042_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model state: where the next fetch must go, the outstanding memory read,
  // and the instruction decode should currently be offered.
  logic [31:0] next_pc;
  logic        pending;
  int          cnt;
  logic [31:0] pend_addr;
  logic [31:0] pend_data;
  logic        pend_err;
  logic        live;
  logic        exp_hold;
  logic [31:0] exp_inst;
  logic [31:0] exp_ipc;
  logic        exp_fault;
  int          idle_run;

  logic        rand_mode;
  logic        stale;
  int          lat;
  logic [31:0] err_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    next_pc  = RESET_PC;
    pending  = 1'b0;
    cnt      = 0;
    live     = 1'b0;
    exp_hold = 1'b0;
    idle_run = 0;
  endtask

  task automatic check_model();
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_hold});
    if (exp_hold) begin
      chk("inst", inst, exp_inst);
      chk("inst_pc", inst_pc, exp_ipc);
      chk("inst_fault", {31'b0, inst_fault}, {31'b0, exp_fault});
    end
    chk("single_outstanding", {31'b0, req_valid && (pending || exp_hold)}, 32'd0);
    if (req_valid) chk("req_addr", req_addr, next_pc);
    chk("addr_align", {30'b0, req_addr[1:0]}, 32'd0);
    if (!rst) begin
      if (!req_valid && !pending && !exp_hold) idle_run++;
      else idle_run = 0;
      chk("no_stall", {31'b0, idle_run > 1}, 32'd0);
    end
  endtask

  // Apply the current inputs across one rising edge, advance the model, then check at the falling edge.
  task automatic tick();
    logic        fire;
    logic        acc;
    logic [31:0] rpc;
    fire      = pending && (cnt == 1);
    rsp_valid = fire || stale;
    rsp_data  = fire ? pend_data : $urandom;
    rsp_err   = fire ? pend_err : ($urandom_range(0, 1) == 1);
    if (rst) begin
      model_reset();
    end else begin
      rpc = {redirect_pc[31:2], 2'b00};
      acc = req_valid && req_ready;
      if (exp_hold && (redirect_valid || inst_ready)) exp_hold = 1'b0;
      if (pending && !fire) cnt--;
      if (fire) begin
        pending = 1'b0;
        if (live && !redirect_valid) begin
          exp_hold  = 1'b1;
          exp_inst  = pend_data;
          exp_ipc   = pend_addr;
          exp_fault = pend_err;
          next_pc   = pend_addr + 32'd4;
        end
        live = 1'b0;
      end
      if (acc) begin
        pending   = 1'b1;
        cnt       = rand_mode ? $urandom_range(1, 4) : lat;
        pend_addr = next_pc;
        pend_data = rand_mode ? $urandom : 32'h0000_0013;
        pend_err  = rand_mode ? ($urandom_range(0, 7) == 0) : (next_pc == err_addr);
        live      = !redirect_valid;
      end
      if (redirect_valid) begin
        next_pc = rpc;
        live    = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic chk_reset_values();
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_req_addr", req_addr, RESET_PC);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_fault", {31'b0, inst_fault}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b1; inst_ready = 1'b1;
    rsp_valid = 1'b0; rsp_data = 32'd0; rsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    rand_mode = 1'b0; stale = 1'b0; lat = 1; err_addr = 32'h8000_0004;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_values();

    // Zero-wait memory, decode always ready; fault on the second word.
    rst = 1'b0;
    tick();
    chk("first_req_valid", {31'b0, req_valid}, 32'd1);
    chk("first_req_addr", req_addr, 32'h8000_0000);
    tick();
    chk("wait_req_low", {31'b0, req_valid}, 32'd0);
    tick();
    chk("i0_valid", {31'b0, inst_valid}, 32'd1);
    chk("i0_pc", inst_pc, 32'h8000_0000);
    chk("i0_inst", inst, 32'h0000_0013);
    chk("i0_fault", {31'b0, inst_fault}, 32'd0);
    tick();
    chk("req1_addr", req_addr, 32'h8000_0004);
    tick(); tick();
    chk("i1_pc", inst_pc, 32'h8000_0004);
    chk("i1_fault", {31'b0, inst_fault}, 32'd1);
    tick();
    chk("req2_addr", req_addr, 32'h8000_0008);
    tick(); tick();
    chk("i2_pc", inst_pc, 32'h8000_0008);
    chk("i2_fault", {31'b0, inst_fault}, 32'd0);

    // Decode back-pressure while holding an instruction.
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("hold_pc", inst_pc, 32'h8000_0008);
      chk("hold_no_req", {31'b0, req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    chk("after_hold_addr", req_addr, 32'h8000_000C);

    // Memory stalls acceptance, then a redirect changes the pending address.
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_req_valid", {31'b0, req_valid}, 32'd1);
      chk("stall_req_addr", req_addr, 32'h8000_000C);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1002;
    tick();
    redirect_valid = 1'b0;
    chk("redir_req_addr", req_addr, 32'h8000_1000);
    req_ready = 1'b1; lat = 4;
    chk("accepted_addr", req_addr, 32'h8000_1000);
    tick();

    // Redirect while waiting; the late response must be dropped.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    lat = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dropped_no_inst", {31'b0, inst_valid}, 32'd0);
    end
    chk("redir_wait_valid", {31'b0, req_valid}, 32'd1);
    chk("redir_wait_addr", req_addr, 32'h8000_0100);

    // Reset in the middle of a wait, then a stale response right after release.
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_reset_values();
    tick();
    rst = 1'b0; stale = 1'b1; lat = 1;
    tick();
    stale = 1'b0;
    chk("restart_valid", {31'b0, req_valid}, 32'd1);
    chk("restart_addr", req_addr, 32'h8000_0000);
    tick(); tick();
    chk("restart_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("restart_inst_pc", inst_pc, 32'h8000_0000);

    // Randomized traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      req_ready      = ($urandom_range(0, 9) < 7);
      inst_ready     = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 99) < 7);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(0, 11)))
                                                   : $urandom;
      rst            = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_23060042_fetch.md
# ysyx_23060042_fetch

Instruction fetch stage of the single-issue RV32 core: owns the PC, issues one instruction read at a time on the instruction-memory request/response bus, and hands each fetched word, with its PC, to the decode stage over a valid/ready handshake. A redirect input from later stages (branch, jump, trap) squashes in-flight work and restarts fetch at a new address. At most one memory request is outstanding.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  output  1  fetch request valid
- req_ready  input  1  memory accepts request this cycle
- req_addr  output  32  fetch address, bits [1:0] always 0
- rsp_valid  input  1  read data returned this cycle
- rsp_data  input  32  instruction word
- rsp_err  input  1  access fault on this response
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts instruction
- inst  output  32  instruction word
- inst_pc  output  32  address of inst
- inst_fault  output  1  inst came from an errored response
- redirect_valid  input  1  restart fetch
- redirect_pc  input  32  restart address; bits [1:0] ignored (forced 0)

## Operation
- Registers: pc, state, drop flag, inst/inst_pc/inst_fault holding registers.
- States: IDLE, REQ, WAIT, HOLD. Outputs decoded from state/registers only (no combinational input-to-output paths).
- IDLE: reset state; unconditionally -> REQ next cycle. redirect_valid here loads pc.
- REQ: req_valid=1, req_addr=pc.
  - req_ready=1 -> WAIT; if redirect_valid same cycle, pc<=redirect_pc and drop<=1.
  - req_ready=0, redirect_valid=1 -> stay REQ, pc<=redirect_pc (bus permits address change before acceptance).
- WAIT: req_valid=0.
  - rsp_valid=1, drop=0, redirect_valid=0 -> capture inst<=rsp_data, inst_pc<=pc, inst_fault<=rsp_err, pc<=pc+4 (mod 2^32), -> HOLD.
  - rsp_valid=1 with drop=1 or redirect_valid=1 -> discard data, drop<=0, pc<=redirect_pc if redirect_valid, -> REQ.
  - rsp_valid=0, redirect_valid=1 -> drop<=1, pc<=redirect_pc, stay WAIT.
- HOLD: inst_valid=1, outputs stable until leaving.
  - redirect_valid=1 -> pc<=redirect_pc, -> REQ (priority over inst_ready; the stage raising redirect ignores any instruction accepted in the same cycle).
  - inst_ready=1 -> REQ.
- Fault responses are passed through, not retried; fetch continues at pc+4 unless redirected.
- Multiple redirects: the latest one wins; drop never counts above 1 (one outstanding request).

## Timing
- Reset values: req_valid=0, req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_fault=0, pc=RESET_PC, drop=0, state=IDLE.
- Reset asserted in any state returns immediately to reset values; a response arriving after reset release without a request is ignored (only sampled in WAIT).
- First req_valid: 1 cycle after rst deasserts.
- Zero-wait memory (req_ready=1, rsp_valid the cycle after acceptance): REQ, WAIT, HOLD = 3 cycles per instruction with inst_ready=1; inst_valid first high 3 cycles after rst release.
- Response latency N cycles after acceptance -> inst_valid rises N+1 cycles after acceptance.
- Redirect seen in HOLD -> req_valid with req_addr=redirect_pc on the next cycle.

## Test plan
- Reset release, req_ready=1, 1-cycle memory returning 0x00000013 -> req_addr 0x80000000, 0x80000004, 0x80000008 in order; inst_pc matches; inst_valid every 3rd cycle.
- inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, req_valid stays 0, no pc advance; release -> next req_addr = inst_pc+4.
- req_ready low 4 cycles, then redirect_pc=0x80001002 while in REQ -> req_addr becomes 0x80001000 next cycle, accepted address is 0x80001000.
- Redirect to 0x80000100 during WAIT, response arrives 3 cycles later -> response discarded, inst_valid never asserted for it, next req_addr=0x80000100.
- rsp_err=1 on 0x80000004 -> inst_fault=1 with inst_pc=0x80000004; next request 0x80000008 with inst_fault=0.
- rst pulsed mid-WAIT, then stale rsp_valid while in IDLE -> ignored; fetch restarts at 0x80000000.
